// File: rtl/fir_tap_ddr_pkg.sv
// Shared definitions for the FIR tap DDR read path: FSM encoding and the tap-line address map.
package fir_tap_ddr_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWait    = 3'd1,
        StReq     = 3'd2,
        StReading = 3'd3,
        StDone    = 3'd4
    } rd_state_e;

    localparam logic [1:0] AddrRegion = 2'd1;
    localparam logic [6:0] LineOffset = 7'd0;

    // Output taps per DDR beat.
    function automatic int unsigned wconv_ratio(input int unsigned mem_bits,
                                                input int unsigned data_bits);
        return mem_bits / data_bits;
    endfunction

    function automatic logic [29:0] tap_line_addr(input logic [15:0] line);
        return {2'd0, AddrRegion, 3'd0, line, LineOffset};
    endfunction

endpackage

// File: rtl/fir_tap_wconv_fifo.sv
// FWFT FIFO taking MEM_DATA_BITS-wide words and emitting DATA_WIDTH slices, LSB slice first.
module fir_tap_wconv_fifo
    import fir_tap_ddr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_DATA_BITS = 256,
    parameter int unsigned FIFO_DEPTH    = 256
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [MEM_DATA_BITS-1:0]       wr_data_i,
    input  logic                           rd_en_i,
    output logic                           rd_vld_o,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    output logic [$clog2(FIFO_DEPTH):0]    occupancy_o,
    output logic                           full_o,
    output logic                           ovf_o
);

    localparam int unsigned Ratio = wconv_ratio(MEM_DATA_BITS, DATA_WIDTH);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned SelW  = (Ratio > 1) ? $clog2(Ratio) : 1;

    logic [MEM_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]            cnt_q;
    logic [SelW-1:0]          sel_q;
    logic                     ovf_q;
    logic                     empty, full, wr_ok, pop, last_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (PtrW + 1)'(FIFO_DEPTH));
    assign wr_ok    = wr_en_i & ~full;
    assign pop      = rd_en_i & ~empty;
    // A word is only freed once its last slice has been popped.
    assign last_pop = pop & (sel_q == SelW'(Ratio - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (last_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (pop) sel_q <= last_pop ? '0 : sel_q + 1'b1;
            cnt_q <= cnt_q + (PtrW + 1)'(wr_ok) - (PtrW + 1)'(last_pop);
            if (wr_en_i && full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_vld_o    = ~empty;
    assign rd_data_o   = empty ? '0 : mem_q[rd_ptr_q][32'(sel_q) * DATA_WIDTH +: DATA_WIDTH];
    assign occupancy_o = cnt_q;
    assign full_o      = full;
    assign ovf_o       = ovf_q;

endmodule

// File: rtl/fir_tap_vout_buffer_ctrl.sv
// Issues one DDR read burst per frame command and streams the returned beats out as FIR taps.
module fir_tap_vout_buffer_ctrl
    import fir_tap_ddr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 30,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_DATA_BITS = 256,
    parameter int unsigned BURST_LEN     = 128,
    parameter int unsigned FIFO_DEPTH    = 256
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_i,
    input  logic                     fir_tap_rd_cmd_i,
    input  logic [31:0]              fir_tap_rd_addr_i,
    output logic                     fir_tap_vld_o,
    output logic [DATA_WIDTH-1:0]    fir_tap_data_o,
    input  logic                     fir_tap_rd_en_i,
    output logic                     ddr_rd_idle_o,
    output logic                     ddr_fifo_ovf_o,
    output logic                     rd_ddr_req_o,
    output logic [7:0]               rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
    input  logic                     ddr_fifo_wr_en_i,
    input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
    input  logic                     rd_ddr_finish_i
);

    rd_state_e                   state_q, state_d;
    logic                        cmd_d0_q, cmd_d1_q, frame_start;
    logic                        req_q;
    logic [7:0]                  len_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [$clog2(FIFO_DEPTH):0] fifo_occ;
    logic                        space_ok;
    logic                        unused_fifo_full;
    logic                        unused_addr_hi;

    assign unused_addr_hi = ^fir_tap_rd_addr_i[31:16];
    assign frame_start    = cmd_d0_q & ~cmd_d1_q;
    // Partially drained words count as occupied, so this is conservative.
    assign space_ok       = (32'(fifo_occ) + BURST_LEN) <= FIFO_DEPTH;

    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            cmd_d0_q <= 1'b0;
            cmd_d1_q <= 1'b0;
            state_q  <= StIdle;
        end else begin
            cmd_d0_q <= fir_tap_rd_cmd_i;
            cmd_d1_q <= cmd_d0_q;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (frame_start) state_d = StWait;
            StWait:    if (space_ok) state_d = StReq;
            StReq:     if (ddr_fifo_wr_en_i || rd_ddr_finish_i) state_d = StReading;
            StReading: if (rd_ddr_finish_i) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            req_q  <= 1'b0;
            len_q  <= '0;
            addr_q <= '0;
        end else if (state_q == StWait && space_ok) begin
            req_q  <= 1'b1;
            len_q  <= 8'(BURST_LEN);
            addr_q <= ADDR_WIDTH'(tap_line_addr(fir_tap_rd_addr_i[15:0]));
        end else if (ddr_fifo_wr_en_i || rd_ddr_finish_i || state_q == StIdle) begin
            req_q  <= 1'b0;
        end
    end

    fir_tap_wconv_fifo #(
        .DATA_WIDTH    (DATA_WIDTH),
        .MEM_DATA_BITS (MEM_DATA_BITS),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (ddr_clk_i),
        .rst_i       (ddr_rst_i),
        .wr_en_i     (ddr_fifo_wr_en_i),
        .wr_data_i   (rd_ddr_data_i),
        .rd_en_i     (fir_tap_rd_en_i),
        .rd_vld_o    (fir_tap_vld_o),
        .rd_data_o   (fir_tap_data_o),
        .occupancy_o (fifo_occ),
        .full_o      (unused_fifo_full),
        .ovf_o       (ddr_fifo_ovf_o)
    );

    assign ddr_rd_idle_o = (state_q == StIdle);
    assign rd_ddr_req_o  = req_q;
    assign rd_ddr_len_o  = len_q;
    assign rd_ddr_addr_o = addr_q;

endmodule

// File: tb/tb_fir_tap_vout_buffer_ctrl.sv
// Bench: default-sized instance for address/latency vectors, small instance for FIFO and FSM corners.
module tb_fir_tap_vout_buffer_ctrl;

    localparam int unsigned SmallDepth = 8;
    localparam int unsigned SmallBurst = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic         cmd_a = 1'b0, rd_en_a = 1'b0, wr_en_a = 1'b0, fin_a = 1'b0;
    logic [31:0]  addr_a = '0;
    logic [255:0] wdata_a = '0;
    logic         vld_a, idle_a, ovf_a, req_a;
    logic [31:0]  data_a;
    logic [7:0]   len_a;
    logic [29:0]  addr_o_a;

    // Instance B: FIFO_DEPTH=8, BURST_LEN=4.
    logic         cmd_b = 1'b0, rd_en_b = 1'b0, wr_en_b = 1'b0, fin_b = 1'b0;
    logic [31:0]  addr_b = '0;
    logic [255:0] wdata_b = '0;
    logic         vld_b, idle_b, ovf_b, req_b;
    logic [31:0]  data_b;
    logic [7:0]   len_b;
    logic [29:0]  addr_o_b;

    fir_tap_vout_buffer_ctrl dut_a (
        .ddr_clk_i         (clk),
        .ddr_rst_i         (rst),
        .fir_tap_rd_cmd_i  (cmd_a),
        .fir_tap_rd_addr_i (addr_a),
        .fir_tap_vld_o     (vld_a),
        .fir_tap_data_o    (data_a),
        .fir_tap_rd_en_i   (rd_en_a),
        .ddr_rd_idle_o     (idle_a),
        .ddr_fifo_ovf_o    (ovf_a),
        .rd_ddr_req_o      (req_a),
        .rd_ddr_len_o      (len_a),
        .rd_ddr_addr_o     (addr_o_a),
        .ddr_fifo_wr_en_i  (wr_en_a),
        .rd_ddr_data_i     (wdata_a),
        .rd_ddr_finish_i   (fin_a)
    );

    fir_tap_vout_buffer_ctrl #(
        .BURST_LEN  (SmallBurst),
        .FIFO_DEPTH (SmallDepth)
    ) dut_b (
        .ddr_clk_i         (clk),
        .ddr_rst_i         (rst),
        .fir_tap_rd_cmd_i  (cmd_b),
        .fir_tap_rd_addr_i (addr_b),
        .fir_tap_vld_o     (vld_b),
        .fir_tap_data_o    (data_b),
        .fir_tap_rd_en_i   (rd_en_b),
        .ddr_rd_idle_o     (idle_b),
        .ddr_fifo_ovf_o    (ovf_b),
        .rd_ddr_req_o      (req_b),
        .rd_ddr_len_o      (len_b),
        .rd_ddr_addr_o     (addr_o_b),
        .ddr_fifo_wr_en_i  (wr_en_b),
        .rd_ddr_data_i     (wdata_b),
        .rd_ddr_finish_i   (fin_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model for instance B: a plain queue of taps; occupied words = ceil(taps/8).
    logic [31:0] mq[$];
    bit          m_ovf = 1'b0;
    logic [31:0] dut_taps[$];
    int          n_req = 0;
    bit          req_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] beat(input int k);
        logic [255:0] b;
        for (int j = 0; j < 8; j++) b[32*j +: 32] = 32'(16 * k + j);
        return b;
    endfunction

    // One clock: update the model with the inputs as they stand, then compare B's tap outputs.
    task automatic cycle();
        int words = (mq.size() + 7) / 8;
        if (vld_b && rd_en_b) dut_taps.push_back(data_b);
        if (rd_en_b && mq.size() > 0) void'(mq.pop_front());
        if (wr_en_b) begin
            if (words >= SmallDepth) m_ovf = 1'b1;
            else for (int j = 0; j < 8; j++) mq.push_back(wdata_b[32*j +: 32]);
        end
        @(posedge clk);
        #1;
        chk("tap_vld", 64'(vld_b), 64'(mq.size() > 0));
        chk("tap_data", 64'(data_b), 64'(mq.size() > 0 ? mq[0] : 32'd0));
        chk("fifo_ovf", 64'(ovf_b), 64'(m_ovf));
        if (req_b && !req_prev) n_req++;
        req_prev = req_b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
        req_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_req_b(input string name, input int bound);
        int k = 0;
        while (!req_b && k < bound) begin
            cycle();
            k++;
        end
        chk(name, 64'(req_b), 64'd1);
    endtask

    task automatic drain_b(input int bound);
        int k = 0;
        rd_en_b = 1'b1;
        while (mq.size() > 0 && k < bound) begin
            cycle();
            k++;
        end
        chk("drain_done", 64'(mq.size()), 64'd0);
    endtask

    typedef struct {
        logic [31:0] cmd_addr;
        logic [29:0] exp_addr;
    } addr_vec_t;

    addr_vec_t tbl [4];
    int        base;

    initial begin
        tbl[0] = '{cmd_addr: 32'h0000_0005, exp_addr: 30'h0400_0280};
        tbl[1] = '{cmd_addr: 32'h0000_FFFF, exp_addr: 30'h047F_FF80};
        tbl[2] = '{cmd_addr: 32'hABCD_0000, exp_addr: 30'h0400_0000};
        tbl[3] = '{cmd_addr: 32'h0000_8001, exp_addr: 30'h0440_0080};

        do_reset();
        chk("rst_idle_a", 64'(idle_a), 64'd1);
        chk("rst_req_a", 64'(req_a), 64'd0);
        chk("rst_len_a", 64'(len_a), 64'd0);
        chk("rst_addr_a", 64'(addr_o_a), 64'd0);
        chk("rst_idle_b", 64'(idle_b), 64'd1);
        chk("rst_vld_b", 64'(vld_b), 64'd0);
        chk("rst_data_b", 64'(data_b), 64'd0);
        chk("rst_ovf_b", 64'(ovf_b), 64'd0);

        // Address map and command-to-request latency on the default-sized instance.
        for (int i = 0; i < 4; i++) begin
            addr_a = tbl[i].cmd_addr;
            cmd_a = 1'b1;
            cycle();
            cycle();
            chk("req_edge2", 64'(req_a), 64'd0);
            chk("idle_in_wait", 64'(idle_a), 64'd0);
            cycle();
            chk("req_edge3", 64'(req_a), 64'd1);
            chk("burst_addr", 64'(addr_o_a), 64'(tbl[i].exp_addr));
            chk("burst_len", 64'(len_a), 64'd128);
            cmd_a = 1'b0;
            fin_a = 1'b1;
            cycle();
            cycle();
            fin_a = 1'b0;
            cycle();
            chk("back_idle_a", 64'(idle_a), 64'd1);
            chk("req_off_a", 64'(req_a), 64'd0);
        end
        chk("a_vld", 64'(vld_a), 64'd0);
        chk("a_data", 64'(data_a), 64'd0);
        chk("a_ovf", 64'(ovf_a), 64'd0);

        // Full burst with a free-running consumer: taps come out LSB slice first.
        do_reset();
        dut_taps.delete();
        rd_en_b = 1'b1;
        addr_b = 32'h0001_0003;
        cmd_b = 1'b1;
        cycle();
        cycle();
        chk("b_req_edge2", 64'(req_b), 64'd0);
        cycle();
        chk("b_req_edge3", 64'(req_b), 64'd1);
        chk("b_len", 64'(len_b), 64'd4);
        chk("b_addr", 64'(addr_o_b), 64'h0400_0180);
        for (int k = 0; k < 4; k++) begin
            wr_en_b = 1'b1;
            wdata_b = beat(k);
            cycle();
            if (k == 0) chk("req_drop_first_beat", 64'(req_b), 64'd0);
        end
        wr_en_b = 1'b0;
        cmd_b = 1'b0;
        fin_b = 1'b1;
        cycle();
        fin_b = 1'b0;
        chk("done_not_idle", 64'(idle_b), 64'd0);
        cycle();
        chk("idle_after_finish", 64'(idle_b), 64'd1);
        drain_b(64);
        chk("tap_count", 64'(dut_taps.size()), 64'd32);
        for (int i = 0; i < dut_taps.size() && i < 32; i++)
            chk("tap_order", 64'(dut_taps[i]), 64'(16 * (i / 8) + (i % 8)));

        // Random traffic: a filling phase that overflows, then a draining phase.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            wr_en_b = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            for (int j = 0; j < 8; j++) wdata_b[32*j +: 32] = $urandom();
            rd_en_b = (c < 200) ? ($urandom_range(0, 1) == 0) : 1'b1;
            cycle();
        end
        wr_en_b = 1'b0;
        drain_b(100);

        // Space check: 6 of 8 words held, so the burst waits until two words are freed.
        do_reset();
        rd_en_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wr_en_b = 1'b1;
            wdata_b = beat(10 + k);
            cycle();
        end
        wr_en_b = 1'b0;
        addr_b = 32'h0000_FFFF;
        cmd_b = 1'b1;
        repeat (8) cycle();
        chk("wait_no_req", 64'(req_b), 64'd0);
        chk("wait_not_idle", 64'(idle_b), 64'd0);
        rd_en_b = 1'b1;
        repeat (16) cycle();
        chk("req_not_yet", 64'(req_b), 64'd0);
        rd_en_b = 1'b0;
        cycle();
        chk("req_after_free", 64'(req_b), 64'd1);
        chk("req_addr_ffff", 64'(addr_o_b), 64'h047F_FF80);

        // Fill to 8 words, then one beat too many.
        for (int k = 0; k < 4; k++) begin
            wr_en_b = 1'b1;
            wdata_b = beat(20 + k);
            cycle();
        end
        wdata_b = beat(30);
        cycle();
        chk("ovf_set", 64'(ovf_b), 64'd1);
        wr_en_b = 1'b0;
        fin_b = 1'b1;
        cmd_b = 1'b0;
        cycle();
        fin_b = 1'b0;
        cycle();
        drain_b(100);
        chk("ovf_sticky", 64'(ovf_b), 64'd1);

        // A second command rise during READING is ignored.
        base = n_req;
        rd_en_b = 1'b1;
        cmd_b = 1'b1;
        wait_req_b("burst1_req", 10);
        wr_en_b = 1'b1;
        wdata_b = beat(40);
        cycle();
        wr_en_b = 1'b0;
        cmd_b = 1'b0;
        repeat (2) cycle();
        cmd_b = 1'b1;
        repeat (3) cycle();
        for (int k = 1; k < 4; k++) begin
            wr_en_b = 1'b1;
            wdata_b = beat(40 + k);
            cycle();
        end
        wr_en_b = 1'b0;
        fin_b = 1'b1;
        cycle();
        fin_b = 1'b0;
        repeat (6) cycle();
        chk("one_burst_only", 64'(n_req - base), 64'd1);
        chk("idle_after_burst1", 64'(idle_b), 64'd1);
        cmd_b = 1'b0;
        repeat (2) cycle();
        cmd_b = 1'b1;
        wait_req_b("burst2_req", 10);
        chk("second_burst", 64'(n_req - base), 64'd2);

        // Asynchronous reset in the middle of READING.
        rd_en_b = 1'b0;
        wr_en_b = 1'b1;
        wdata_b = beat(50);
        cycle();
        wr_en_b = 1'b0;
        #2;
        rst = 1'b1;
        cmd_b = 1'b0;
        #1;
        chk("arst_req", 64'(req_b), 64'd0);
        chk("arst_vld", 64'(vld_b), 64'd0);
        chk("arst_ovf", 64'(ovf_b), 64'd0);
        chk("arst_idle", 64'(idle_b), 64'd1);
        mq.delete();
        m_ovf = 1'b0;
        req_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        addr_b = 32'h0000_1234;
        cmd_b = 1'b1;
        wait_req_b("req_after_arst", 10);
        chk("addr_after_arst", 64'(addr_o_b), 64'h0409_1A00);
        chk("len_after_arst", 64'(len_b), 64'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
